cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Common-data-bus arbiter between the ALU result port and the LSB result port. Each producer pushes `(RobId, value)` results into a private FIFO. Each cycle the arbiter grants at most one FIFO head onto a single registered broadcast bus. That bus feeds the RS, LSB and ROB wake-up/commit logic. With this block the consumers see one result bus instead of separate `exc_*` / `LSB_*` ports.

## Interface
Parameters:
- `ROB_LOG`, default 4: width of ROB index.
- `DEPTH`, default 2: entries per source FIFO; must be a power of two, ≥ 2.

Ports:
- `clk` input, 1 bit: the single clock. All state is updated on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `rdy` input, 1 bit: global ready. When low, all state holds.
- `jump_flag` input, 1 bit: mispredict flush.
- `alu_valid` input, 1 bit: ALU result present.
- `alu_RobId` input, `ROB_LOG` bits: ALU destination ROB entry.
- `alu_value` input, 32 bits: ALU result value.
- `alu_ready` output, 1 bit: ALU FIFO can accept. Combinational: `rdy && alu_count < DEPTH`.
- `lsb_valid` input, 1 bit: LSB result present.
- `lsb_RobId` input, `ROB_LOG` bits: LSB destination ROB entry.
- `lsb_value` input, 32 bits: LSB result value.
- `lsb_ready` output, 1 bit: LSB FIFO can accept. Same rule as `alu_ready`.
- `cdb_valid` output reg, 1 bit: broadcast valid.
- `cdb_RobId` output reg, `ROB_LOG` bits: broadcast ROB id.
- `cdb_value` output reg, 32 bits: broadcast value.
- `cdb_src` output reg, 1 bit: source of the current broadcast; 0 = ALU, 1 = LSB.

## Operation
**FIFOs**
- Two identical circular FIFOs, one per source.
- Each FIFO has head and tail pointers of width log2(`DEPTH`), wrapping modulo `DEPTH`.
- Each FIFO has a count of width log2(`DEPTH`)+1.
- Push: on an edge with `x_valid && x_ready`, the entry is written at the tail and the tail increments.
- A full FIFO rejects the push even if it pops in the same cycle, because `ready` is based on the count before the edge. A source that sees `ready` low holds its result.

**Grant** (combinational, from the FIFO counts)
- Only the ALU FIFO non-empty: grant the ALU.
- Only the LSB FIFO non-empty: grant the LSB.
- Both non-empty: the `last_grant` policy decides (see Configuration).
- Neither non-empty: no grant.

**Broadcast** (on each edge with `rdy`)
- With a grant:
  - The granted FIFO pops (head increments, count decrements).
  - `cdb_valid <= 1`, `cdb_RobId`/`cdb_value` take the head entry, `cdb_src` takes the granted source.
  - `last_grant` takes the granted source.
- With no grant: `cdb_valid <= 0`. `cdb_RobId`, `cdb_value` and `cdb_src` hold.

**Simultaneous push and pop on one FIFO:** count is unchanged, both pointers advance.

**`jump_flag`** (synchronous, priority over everything except `rst`)
- Empties both FIFOs: pointers and counts go to 0.
- `cdb_valid <= 0`, `last_grant <= 1`, so the ALU wins the next tie.
- A push presented in the same cycle is dropped.

**`rdy` low**
- No push, no pop.
- All registers hold, including `cdb_valid`.

**`rst`** (asynchronous, may assert mid-operation)
- FIFOs are emptied immediately.
- `cdb_valid = 0`, `cdb_RobId = 0`, `cdb_value = 0`, `cdb_src = 0`, `last_grant = 1`.
- After reset, `alu_ready` and `lsb_ready` equal `rdy`.

## Timing
- Latency: a result pushed at edge N is broadcast at the earliest from edge N+1. `cdb_valid` is then high during the cycle that follows edge N+1.
- There is no bypass path from the inputs to the CDB.
- Throughput: at most one broadcast per cycle in total. Each accepted result is broadcast exactly once.
- `cdb_valid` is high for exactly one cycle per entry, provided `rdy` stays high.
- Each FIFO drains in order. The two sources may interleave with each other.

## Configuration
- Macro: `CDB_RR_EN`.
- Defined: round-robin on tie.
  - The source not equal to `last_grant` wins.
  - Under continuous contention the grants alternate ALU, LSB, ALU, and so on.
- Undefined: fixed priority. The ALU always wins a tie and `last_grant` is unused.
  - Starvation of the LSB is accepted in this mode. The ALU issue rate is bounded by the RS.

## Test plan
1. Reset:
   - Stimulus: assert `rst` asynchronously mid-cycle while both FIFOs hold data.
   - Required: `cdb_valid` = 0 immediately; `alu_ready` = `lsb_ready` = 1 after release with `rdy` = 1; no stale broadcast afterwards.
2. Single source:
   - Stimulus: ALU pushes (`RobId` 3, `0xDEADBEEF`) at edge 1.
   - Required: `cdb_valid` = 1, `cdb_RobId` = 3, `cdb_value` = `0xDEADBEEF`, `cdb_src` = 0 for the one cycle after edge 2; then 0.
3. Contention:
   - Stimulus: both sources push every cycle for 6 cycles, with `CDB_RR_EN` defined.
   - Required: `cdb_src` sequence 0,1,0,1,…; `ready` drops once a FIFO holds `DEPTH` entries; no entry is lost or duplicated (scoreboard the `RobId`s).
4. Fixed priority:
   - Stimulus: same as test 3 with `CDB_RR_EN` undefined.
   - Required: every broadcast is from the ALU while the ALU FIFO is non-empty; `lsb_ready` stays 0 once the LSB FIFO is full.
5. Flush:
   - Stimulus: fill both FIFOs (`DEPTH` = 2), then pulse `jump_flag` together with a new ALU push.
   - Required: next cycle `cdb_valid` = 0, both counts = 0, the new push is dropped; the next tie is won by the ALU.
6. Stall and wrap-around:
   - Stimulus: hold `rdy` = 0 for 3 cycles with `cdb_valid` = 1; then stream 5 ALU entries (`RobId`s 0-4).
   - Required: outputs are frozen during the stall; afterwards the entries are broadcast in order 0-4 across the pointer wrap.

Source files
------------

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Merges the ALU and LSB result streams onto one registered common data bus.
// Each producer pushes (RobId, value) pairs into its own small circular FIFO.
// Every cycle, at most one FIFO head is granted onto the broadcast registers.
//
// Optional feature macro: CDB_RR_EN
//   defined   : round-robin on a tie. The source other than last_grant wins.
//   undefined : fixed priority. The ALU always wins a tie.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   rdy                 : global ready; when low every register holds
//   jump_flag           : mispredict flush; empties both FIFOs, drops pushes
//   alu_valid/RobId/value, alu_ready : ALU producer handshake
//   lsb_valid/RobId/value, lsb_ready : LSB producer handshake
//   cdb_valid/RobId/value/src        : registered broadcast (src 0=ALU, 1=LSB)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int ROB_LOG = 4,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               jump_flag,
  input  logic               alu_valid,
  input  logic [ROB_LOG-1:0] alu_RobId,
  input  logic [31:0]        alu_value,
  output logic               alu_ready,
  input  logic               lsb_valid,
  input  logic [ROB_LOG-1:0] lsb_RobId,
  input  logic [31:0]        lsb_value,
  output logic               lsb_ready,
  output logic               cdb_valid,
  output logic [ROB_LOG-1:0] cdb_RobId,
  output logic [31:0]        cdb_value,
  output logic               cdb_src
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Source-indexed views of the two producers (index 0 = ALU, 1 = LSB).
  logic [1:0]         in_valid;
  logic [ROB_LOG-1:0] in_id  [2];
  logic [31:0]        in_val [2];
  logic [1:0]         ready;
  logic [1:0]         non_empty;
  logic [ROB_LOG-1:0] head_id  [2];
  logic [31:0]        head_val [2];

  assign in_valid  = {lsb_valid, alu_valid};
  assign in_id[0]  = alu_RobId;
  assign in_id[1]  = lsb_RobId;
  assign in_val[0] = alu_value;
  assign in_val[1] = lsb_value;
  assign alu_ready = ready[0];
  assign lsb_ready = ready[1];

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  logic grant_valid;
  logic grant_src;
  logic tie_src;

`ifdef CDB_RR_EN
  logic last_grant_q;

  // On a tie, the source that did not win last time goes next.
  assign tie_src = ~last_grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (jump_flag) begin
      last_grant_q <= 1'b1;
    end else if (rdy && grant_valid) begin
      last_grant_q <= grant_src;
    end
  end
`else
  assign tie_src = 1'b0;
`endif

  always_comb begin
    grant_valid = |non_empty;
    grant_src   = 1'b0;
    if (&non_empty) begin
      grant_src = tie_src;
    end else begin
      grant_src = non_empty[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Per-source circular FIFOs
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [ROB_LOG-1:0] id_mem  [DEPTH];
      logic [31:0]        val_mem [DEPTH];
      logic [PTR_W-1:0]   head_q, head_d;
      logic [PTR_W-1:0]   tail_q, tail_d;
      logic [CNT_W-1:0]   count_q, count_d;
      logic               push;
      logic               pop;

      // Ready depends only on the count before the edge, so a full FIFO
      // refuses a push even when it pops on the same edge.
      assign ready[gi]     = rdy && (count_q < CNT_W'(DEPTH));
      assign push          = rdy && !jump_flag && in_valid[gi] && ready[gi];
      assign pop           = rdy && !jump_flag && grant_valid && (grant_src == 1'(gi));
      assign non_empty[gi] = (count_q != '0);
      assign head_id[gi]   = id_mem[head_q];
      assign head_val[gi]  = val_mem[head_q];

      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (jump_flag) begin
          head_d  = '0;
          tail_d  = '0;
          count_d = '0;
        end else begin
          if (push) tail_d = tail_q + PTR_W'(1);
          if (pop)  head_d = head_q + PTR_W'(1);
          case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          head_q  <= '0;
          tail_q  <= '0;
          count_q <= '0;
        end else begin
          head_q  <= head_d;
          tail_q  <= tail_d;
          count_q <= count_d;
        end
      end

      // Storage needs no reset; occupancy is tracked by count_q alone.
      always_ff @(posedge clk) begin
        if (push) begin
          id_mem[tail_q]  <= in_id[gi];
          val_mem[tail_q] <= in_val[gi];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Broadcast registers
  // ---------------------------------------------------------------------------
  logic               cdb_valid_q;
  logic [ROB_LOG-1:0] cdb_id_q;
  logic [31:0]        cdb_value_q;
  logic               cdb_src_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_id_q    <= '0;
      cdb_value_q <= '0;
      cdb_src_q   <= 1'b0;
    end else if (jump_flag) begin
      cdb_valid_q <= 1'b0;
    end else if (rdy) begin
      cdb_valid_q <= grant_valid;
      if (grant_valid) begin
        cdb_id_q    <= head_id[grant_src];
        cdb_value_q <= head_val[grant_src];
        cdb_src_q   <= grant_src;
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_RobId = cdb_id_q;
  assign cdb_value = cdb_value_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed bench for cdb_arbiter (ROB_LOG = 4, DEPTH = 2). Expected values are
// hand-computed tables. Build with or without CDB_RR_EN; the contention
// table follows the same macro.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        jump_flag;
  logic        alu_valid;
  logic [3:0]  alu_RobId;
  logic [31:0] alu_value;
  logic        alu_ready;
  logic        lsb_valid;
  logic [3:0]  lsb_RobId;
  logic [31:0] lsb_value;
  logic        lsb_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_RobId;
  logic [31:0] cdb_value;
  logic        cdb_src;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter #(.ROB_LOG(4), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .jump_flag (jump_flag),
    .alu_valid (alu_valid),
    .alu_RobId (alu_RobId),
    .alu_value (alu_value),
    .alu_ready (alu_ready),
    .lsb_valid (lsb_valid),
    .lsb_RobId (lsb_RobId),
    .lsb_value (lsb_value),
    .lsb_ready (lsb_ready),
    .cdb_valid (cdb_valid),
    .cdb_RobId (cdb_RobId),
    .cdb_value (cdb_value),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    alu_RobId = '0;
    alu_value = '0;
    lsb_valid = 1'b0;
    lsb_RobId = '0;
    lsb_value = '0;
    jump_flag = 1'b0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rdy = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_alu(input logic [3:0] id, input logic [31:0] val);
    alu_valid = 1'b1;
    alu_RobId = id;
    alu_value = val;
  endtask

  task automatic push_lsb(input logic [3:0] id, input logic [31:0] val);
    lsb_valid = 1'b1;
    lsb_RobId = id;
    lsb_value = val;
  endtask

  // Contention bookkeeping
  logic [13:0] exp_v, exp_s, exp_lr, exp_ar;
  int          ai, li, na, nl;
  logic        acc_a, acc_l;

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- Reset state ----------------
    idle_inputs();
    rdy = 1'b1;
    rst = 1'b1;
    #2;
    check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    check("rst_cdb_value", cdb_value, 32'd0);
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    check("rst_lsb_ready", 32'(lsb_ready), 32'd1);
    tick();
    rst = 1'b0;

    // ---------------- Single source ----------------
    push_alu(4'd3, 32'hDEADBEEF);
    tick();                                  // edge 1: push
    idle_inputs();
    check("single_no_bypass", 32'(cdb_valid), 32'd0);
    tick();                                  // edge 2: broadcast
    check("single_valid", 32'(cdb_valid), 32'd1);
    check("single_id", 32'(cdb_RobId), 32'd3);
    check("single_value", cdb_value, 32'hDEADBEEF);
    check("single_src", 32'(cdb_src), 32'd0);
    tick();
    check("single_valid_drop", 32'(cdb_valid), 32'd0);
    check("single_value_hold", cdb_value, 32'hDEADBEEF);

    // ---------------- Async reset mid-operation ----------------
    push_alu(4'd1, 32'h11);
    push_lsb(4'd2, 32'h22);
    tick();
    push_alu(4'd4, 32'h44);
    push_lsb(4'd5, 32'h55);
    tick();
    idle_inputs();
    check("pre_rst_valid", 32'(cdb_valid), 32'd1);
    #3;
    rst = 1'b1;                              // mid-cycle, no clock edge
    #1;
    check("async_rst_valid", 32'(cdb_valid), 32'd0);
    check("async_rst_id", 32'(cdb_RobId), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("post_rst_alu_ready", 32'(alu_ready), 32'd1);
    check("post_rst_lsb_ready", 32'(lsb_ready), 32'd1);
    tick();
    check("post_rst_no_stale_1", 32'(cdb_valid), 32'd0);
    tick();
    check("post_rst_no_stale_2", 32'(cdb_valid), 32'd0);

    // ---------------- Contention ----------------
    // Bit c = state just after edge c+1. ALU ids 0..5, LSB ids 8..13.
    exp_v = 14'b01_1111_1111_1110;
`ifdef CDB_RR_EN
    exp_s  = 14'b01_0101_0101_0100;
    exp_lr = 14'b11_1101_0101_0101;
    exp_ar = 14'b11_1110_1010_1011;
`else
    exp_s  = 14'b01_1111_1000_0000;
    exp_lr = 14'b11_1111_1000_0001;
    exp_ar = 14'b11_1111_1111_1111;
`endif
    reset_dut();
    ai = 0; li = 0; na = 0; nl = 0;
    for (int c = 0; c < 14; c++) begin
      alu_valid = (ai < 6);
      alu_RobId = 4'(ai);
      alu_value = 32'hA000_0000 + 32'(ai);
      lsb_valid = (li < 6);
      lsb_RobId = 4'(8 + li);
      lsb_value = 32'hB000_0000 + 32'(li);
      acc_a = alu_valid && alu_ready;
      acc_l = lsb_valid && lsb_ready;
      tick();
      if (acc_a) ai++;
      if (acc_l) li++;
      check($sformatf("cont%0d_valid", c), 32'(cdb_valid), 32'(exp_v[c]));
      check($sformatf("cont%0d_lsb_ready", c), 32'(lsb_ready), 32'(exp_lr[c]));
      check($sformatf("cont%0d_alu_ready", c), 32'(alu_ready), 32'(exp_ar[c]));
      if (exp_v[c]) begin
        check($sformatf("cont%0d_src", c), 32'(cdb_src), 32'(exp_s[c]));
        if (exp_s[c]) begin
          check($sformatf("cont%0d_lsb_id", c), 32'(cdb_RobId), 32'(8 + nl));
          check($sformatf("cont%0d_lsb_val", c), cdb_value, 32'hB000_0000 + 32'(nl));
          nl++;
        end else begin
          check($sformatf("cont%0d_alu_id", c), 32'(cdb_RobId), 32'(na));
          check($sformatf("cont%0d_alu_val", c), cdb_value, 32'hA000_0000 + 32'(na));
          na++;
        end
      end
    end
    idle_inputs();
    check("cont_alu_accepted", 32'(ai), 32'd6);
    check("cont_lsb_accepted", 32'(li), 32'd6);

    // ---------------- Flush ----------------
    reset_dut();
    push_alu(4'd10, 32'h1010);
    push_lsb(4'd11, 32'h1111);
    tick();                                  // both FIFOs hold one
    push_alu(4'd12, 32'h1212);
    push_lsb(4'd13, 32'h1313);
    tick();                                  // ALU 10 broadcast, LSB full
    check("flush_pre_id", 32'(cdb_RobId), 32'd10);
    check("flush_pre_lsb_full", 32'(lsb_ready), 32'd0);
    idle_inputs();
    jump_flag = 1'b1;
    push_alu(4'd7, 32'h0707);                // must be dropped
    tick();
    idle_inputs();
    check("flush_valid", 32'(cdb_valid), 32'd0);
    check("flush_alu_ready", 32'(alu_ready), 32'd1);
    check("flush_lsb_ready", 32'(lsb_ready), 32'd1);
    tick();
    check("flush_empty", 32'(cdb_valid), 32'd0);
    push_alu(4'd14, 32'h2020);
    push_lsb(4'd15, 32'h2121);
    tick();
    idle_inputs();
    tick();
    check("flush_tie_src", 32'(cdb_src), 32'd0);
    check("flush_tie_id", 32'(cdb_RobId), 32'd14);
    tick();
    check("flush_second_src", 32'(cdb_src), 32'd1);
    check("flush_second_id", 32'(cdb_RobId), 32'd15);
    tick();
    check("flush_drained", 32'(cdb_valid), 32'd0);

    // ---------------- Stall and wrap-around ----------------
    reset_dut();
    push_alu(4'd5, 32'h5555);
    tick();
    idle_inputs();
    tick();
    check("stall_pre_valid", 32'(cdb_valid), 32'd1);
    rdy = 1'b0;
    push_alu(4'd9, 32'h9999);                // not accepted while stalled
    #1;
    check("stall_alu_ready", 32'(alu_ready), 32'd0);
    check("stall_lsb_ready", 32'(lsb_ready), 32'd0);
    for (int s = 0; s < 3; s++) begin
      tick();
      check($sformatf("stall%0d_valid", s), 32'(cdb_valid), 32'd1);
      check($sformatf("stall%0d_id", s), 32'(cdb_RobId), 32'd5);
      check($sformatf("stall%0d_value", s), cdb_value, 32'h5555);
    end
    rdy = 1'b1;
    idle_inputs();
    tick();
    check("stall_release_valid", 32'(cdb_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      if (k < 5) push_alu(4'(k), 32'h0C00 + 32'(k));
      else idle_inputs();
      tick();
      if (k == 0) begin
        check("wrap_first_latency", 32'(cdb_valid), 32'd0);
      end else begin
        check($sformatf("wrap%0d_valid", k - 1), 32'(cdb_valid), 32'd1);
        check($sformatf("wrap%0d_id", k - 1), 32'(cdb_RobId), 32'(k - 1));
        check($sformatf("wrap%0d_value", k - 1), cdb_value, 32'h0C00 + 32'(k - 1));
      end
    end
    tick();
    check("wrap_done", 32'(cdb_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
